// File: rtl/register_file_mp.sv
// Multi-port MIPS register file: N combinational read ports, two synchronous write ports, optional bypass.
// Define REGFILE_SCOREBOARD_EN to add per-register busy tracking (REG_sb_set/REG_sb_addr/REG_sb_busy).
module register_file_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned ADDR_W  = $clog2(DEPTH)
) (
  input  logic                     REG_clk,
  input  logic                     REG_rst,
  input  logic [NUM_RD*ADDR_W-1:0] REG_address_rd,
  output logic [NUM_RD*DATA_W-1:0] REG_data_out,
  input  logic                     REG_write_1,
  input  logic [ADDR_W-1:0]        REG_address_wr1,
  input  logic [DATA_W-1:0]        REG_data_wb_in1,
  input  logic                     REG_write_2,
  input  logic [ADDR_W-1:0]        REG_address_wr2,
  input  logic [DATA_W-1:0]        REG_data_wb_in2
`ifdef REGFILE_SCOREBOARD_EN
  ,
  input  logic                     REG_sb_set,
  input  logic [ADDR_W-1:0]        REG_sb_addr,
  output logic [NUM_RD-1:0]        REG_sb_busy
`endif
);

  logic [DATA_W-1:0] regs [DEPTH];
  logic              we1;
  logic              we2;

  // Address is backed by a real register (matters only for non-power-of-2 DEPTH)
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < (ADDR_W+1)'(DEPTH));
  endfunction

  // Address is a live register: in range and not the hardwired zero
  function automatic logic addr_live(input logic [ADDR_W-1:0] a);
    return addr_ok(a) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign we1 = REG_write_1 && addr_live(REG_address_wr1);
  assign we2 = REG_write_2 && addr_live(REG_address_wr2);

  // Array update; port 2 is assigned last so it wins an address collision
  always_ff @(posedge REG_clk or posedge REG_rst) begin
    if (REG_rst) begin
      for (int i = 0; i < int'(DEPTH); i++) regs[i] <= '0;
    end else begin
      if (we1) regs[REG_address_wr1] <= REG_data_wb_in1;
      if (we2) regs[REG_address_wr2] <= REG_data_wb_in2;
    end
  end

  // Combinational read ports with optional same-cycle forwarding
  always_comb begin
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] val;
    REG_data_out = '0;
    for (int i = 0; i < int'(NUM_RD); i++) begin
      ra  = REG_address_rd[i*ADDR_W +: ADDR_W];
      val = '0;
      if (!REG_rst && addr_live(ra)) begin
        val = regs[ra];
        if (BYPASS != 0) begin
          if (we1 && (REG_address_wr1 == ra)) val = REG_data_wb_in1;
          if (we2 && (REG_address_wr2 == ra)) val = REG_data_wb_in2;
        end
      end
      REG_data_out[i*DATA_W +: DATA_W] = val;
    end
  end

`ifdef REGFILE_SCOREBOARD_EN
  logic [DEPTH-1:0] busy;
  logic             sb_ok;

  assign sb_ok = REG_sb_set && addr_live(REG_sb_addr);

  // Retiring writes clear, issue sets; set is applied last so a new producer wins
  always_ff @(posedge REG_clk or posedge REG_rst) begin
    if (REG_rst) begin
      busy <= '0;
    end else begin
      if (we1)   busy[REG_address_wr1] <= 1'b0;
      if (we2)   busy[REG_address_wr2] <= 1'b0;
      if (sb_ok) busy[REG_sb_addr]     <= 1'b1;
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] ra;
    logic              hit;
    REG_sb_busy = '0;
    for (int i = 0; i < int'(NUM_RD); i++) begin
      ra  = REG_address_rd[i*ADDR_W +: ADDR_W];
      hit = (we1 && (REG_address_wr1 == ra)) || (we2 && (REG_address_wr2 == ra));
      if (!REG_rst && addr_live(ra))
        REG_sb_busy[i] = busy[ra] && !((BYPASS != 0) && hit);
    end
  end
`endif

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp; a bypass and a non-bypass instance share the same stimulus.
module tb_register_file_mp;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [2*AW-1:0] rd_addr;
  logic [2*DW-1:0] dout, dout_nb;
  logic          w1, w2;
  logic [AW-1:0] a1, a2;
  logic [DW-1:0] d1, d2;
`ifdef REGFILE_SCOREBOARD_EN
  logic          sb_set;
  logic [AW-1:0] sb_addr;
  logic [1:0]    busy, busy_nb;
`endif

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  register_file_mp #(.BYPASS(1)) dut (
    .REG_clk(clk), .REG_rst(rst), .REG_address_rd(rd_addr), .REG_data_out(dout),
    .REG_write_1(w1), .REG_address_wr1(a1), .REG_data_wb_in1(d1),
    .REG_write_2(w2), .REG_address_wr2(a2), .REG_data_wb_in2(d2)
`ifdef REGFILE_SCOREBOARD_EN
    , .REG_sb_set(sb_set), .REG_sb_addr(sb_addr), .REG_sb_busy(busy)
`endif
  );

  register_file_mp #(.BYPASS(0)) dut_nb (
    .REG_clk(clk), .REG_rst(rst), .REG_address_rd(rd_addr), .REG_data_out(dout_nb),
    .REG_write_1(w1), .REG_address_wr1(a1), .REG_data_wb_in1(d1),
    .REG_write_2(w2), .REG_address_wr2(a2), .REG_data_wb_in2(d2)
`ifdef REGFILE_SCOREBOARD_EN
    , .REG_sb_set(sb_set), .REG_sb_addr(sb_addr), .REG_sb_busy(busy_nb)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    w1 = 1'b0; w2 = 1'b0;
`ifdef REGFILE_SCOREBOARD_EN
    sb_set = 1'b0;
`endif
  endtask

  task automatic rd(input logic [AW-1:0] p0, input logic [AW-1:0] p1);
    rd_addr = {p1, p0};
    #1;
  endtask

  task automatic test_reset();
    w1 = 1'b1; a1 = 5'd5; d1 = 32'h0000_1234;
    rd(5'd5, 5'd5);
    checks++;
    if (dout !== 64'h0) $display("FAIL reset_hold_bypass got=%h exp=0", dout); else passed++;
    tick();
    checks++;
    if (dout_nb !== 64'h0) $display("FAIL reset_hold got=%h exp=0", dout_nb); else passed++;
    idle();
    #2 rst = 1'b0;
    tick();
    checks++;
    if (dout !== 64'h0) $display("FAIL reset_write_discarded got=%h exp=0", dout); else passed++;
    w1 = 1'b1; a1 = 5'd5; d1 = 32'hDEAD_BEEF;
    tick();
    idle();
    rd(5'd5, 5'd5);
    checks++;
    if (dout_nb !== {2{32'hDEAD_BEEF}}) $display("FAIL r5_written got=%h exp=%h", dout_nb, {2{32'hDEAD_BEEF}}); else passed++;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (dout !== 64'h0) $display("FAIL reset_mid_run got=%h exp=0", dout); else passed++;
    tick();
    #1 rst = 1'b0;
    tick();
    checks++;
    if (dout_nb !== 64'h0) $display("FAIL r5_after_release got=%h exp=0", dout_nb); else passed++;
  endtask

  task automatic test_dual_write();
    w1 = 1'b1; a1 = 5'd7; d1 = 32'h11;
    w2 = 1'b1; a2 = 5'd7; d2 = 32'h22;
    rd(5'd7, 5'd7);
    checks++;
    if (dout[31:0] !== 32'h22) $display("FAIL collide_bypass got=%h exp=22", dout[31:0]); else passed++;
    checks++;
    if (dout_nb[31:0] !== 32'h0) $display("FAIL collide_nobypass_old got=%h exp=0", dout_nb[31:0]); else passed++;
    tick();
    idle();
    #1;
    checks++;
    if (dout_nb !== {2{32'h22}}) $display("FAIL collide_commit got=%h exp=%h", dout_nb, {2{32'h22}}); else passed++;
    w1 = 1'b1; a1 = 5'd3; d1 = 32'hA;
    w2 = 1'b1; a2 = 5'd4; d2 = 32'hB;
    tick();
    idle();
    rd(5'd3, 5'd4);
    checks++;
    if (dout_nb !== {32'hB, 32'hA}) $display("FAIL dual_commit got=%h exp=%h", dout_nb, {32'hB, 32'hA}); else passed++;
    checks++;
    if (dout !== {32'hB, 32'hA}) $display("FAIL dual_commit_bypass_inst got=%h exp=%h", dout, {32'hB, 32'hA}); else passed++;
  endtask

  task automatic test_bypass();
    w1 = 1'b1; a1 = 5'd9; d1 = 32'h33;
    tick();
    idle();
    w1 = 1'b1; a1 = 5'd9; d1 = 32'h55;
    rd(5'd9, 5'd3);
    checks++;
    if (dout !== {32'hA, 32'h55}) $display("FAIL bypass_same_cycle got=%h exp=%h", dout, {32'hA, 32'h55}); else passed++;
    checks++;
    if (dout_nb !== {32'hA, 32'h33}) $display("FAIL nobypass_old got=%h exp=%h", dout_nb, {32'hA, 32'h33}); else passed++;
    tick();
    idle();
    #1;
    checks++;
    if (dout_nb[31:0] !== 32'h55) $display("FAIL nobypass_next got=%h exp=55", dout_nb[31:0]); else passed++;
  endtask

  task automatic test_zero_reg();
    w1 = 1'b1; a1 = 5'd0; d1 = 32'hFFFF_FFFF;
    w2 = 1'b1; a2 = 5'd0; d2 = 32'hFFFF_FFFF;
    rd(5'd0, 5'd0);
    checks++;
    if (dout !== 64'h0) $display("FAIL zero_bypass got=%h exp=0", dout); else passed++;
    tick();
    idle();
    #1;
    checks++;
    if (dout !== 64'h0) $display("FAIL zero_after got=%h exp=0", dout); else passed++;
    checks++;
    if (dout_nb !== 64'h0) $display("FAIL zero_after_nb got=%h exp=0", dout_nb); else passed++;
  endtask

`ifdef REGFILE_SCOREBOARD_EN
  task automatic test_scoreboard();
    rd(5'd12, 5'd13);
    checks++;
    if (busy !== 2'b00) $display("FAIL sb_initial got=%b exp=00", busy); else passed++;
    sb_set = 1'b1; sb_addr = 5'd12;
    tick();
    idle();
    #1;
    checks++;
    if (busy !== 2'b01) $display("FAIL sb_set got=%b exp=01", busy); else passed++;
    w1 = 1'b1; a1 = 5'd12; d1 = 32'h77;
    #1;
    checks++;
    if (busy !== 2'b00) $display("FAIL sb_bypass_forced got=%b exp=00", busy); else passed++;
    checks++;
    if (busy_nb !== 2'b01) $display("FAIL sb_nobypass_busy got=%b exp=01", busy_nb); else passed++;
    tick();
    idle();
    #1;
    checks++;
    if (busy_nb !== 2'b00) $display("FAIL sb_clear got=%b exp=00", busy_nb); else passed++;
    sb_set = 1'b1; sb_addr = 5'd12;
    w2 = 1'b1; a2 = 5'd12; d2 = 32'h99;
    tick();
    idle();
    #1;
    checks++;
    if (busy !== 2'b01) $display("FAIL sb_set_wins got=%b exp=01", busy); else passed++;
    checks++;
    if (dout[31:0] !== 32'h99) $display("FAIL sb_set_wins_data got=%h exp=99", dout[31:0]); else passed++;
    sb_set = 1'b1; sb_addr = 5'd0;
    tick();
    idle();
    rd(5'd0, 5'd12);
    checks++;
    if (busy !== 2'b10) $display("FAIL sb_zero_reg got=%b exp=10", busy); else passed++;
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 2'b00) $display("FAIL sb_reset got=%b exp=00", busy); else passed++;
    tick();
    #1 rst = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1;
    rd_addr = '0;
    a1 = '0; a2 = '0; d1 = '0; d2 = '0;
`ifdef REGFILE_SCOREBOARD_EN
    sb_addr = '0;
`endif
    idle();
    tick();
    tick();
    test_reset();
    test_dual_write();
    test_bypass();
    test_zero_reg();
`ifdef REGFILE_SCOREBOARD_EN
    test_scoreboard();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
